// File: rtl/riscv_pkg.sv
// Shared core constants: writeback source indices, the hardwired-zero register,
// and the default regfile geometry.
package riscv_pkg;

  localparam int RF_WIDTH      = 32;
  localparam int RF_ADDR_WIDTH = 5;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_t;

  localparam logic [RF_ADDR_WIDTH-1:0] REG_X0 = '0;

  function automatic wb_src_t other_src(input wb_src_t s);
    return (s == SRC_ALU) ? SRC_LSU : SRC_ALU;
  endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// Forwards the in-flight writeback onto one regfile read port; x0 is never forwarded.
// Purely combinational, no backpressure. Compiled only when RF_BYPASS_EN is defined.
`ifdef RF_BYPASS_EN
module rf_bypass_mux
  import riscv_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [WIDTH-1:0]      wb_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      rf_rdata,
  output logic [WIDTH-1:0]      rdata
);

  logic hit;

  assign hit   = wb_valid & (wb_addr == rd_addr) & (rd_addr != ADDR_WIDTH'(REG_X0));
  assign rdata = hit ? wb_data : rf_rdata;

endmodule
`endif

// File: rtl/regfile_wb_arbiter.sv
// Round-robin share of the regfile write port between ALU and LSU; one-cycle registered write,
// lone requester always accepted, loser of a contention waits one cycle. RF_BYPASS_EN adds read forwarding.
module regfile_wb_arbiter
  import riscv_pkg::*;
#(
  parameter int WIDTH      = RF_WIDTH,
  parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  clear,
  input  logic                  s0_valid,
  input  logic [ADDR_WIDTH-1:0] s0_addr,
  input  logic [WIDTH-1:0]      s0_data,
  output logic                  s0_ready,
  input  logic                  s1_valid,
  input  logic [ADDR_WIDTH-1:0] s1_addr,
  input  logic [WIDTH-1:0]      s1_data,
  output logic                  s1_ready,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [WIDTH-1:0]      rf_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic [WIDTH-1:0]      rf_rdata_a,
  input  logic [WIDTH-1:0]      rf_rdata_b,
  output logic [WIDTH-1:0]      rdata_a,
  output logic [WIDTH-1:0]      rdata_b,
  output logic [CNT_WIDTH-1:0]  stall0_cnt,
  output logic [CNT_WIDTH-1:0]  stall1_cnt
);

  wb_src_t               prio;
  logic                  contend;
  logic                  grant0;
  logic                  grant1;
  logic                  any_grant;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [WIDTH-1:0]      win_data;

  logic                  wb_valid_q;
  logic [ADDR_WIDTH-1:0] wb_addr_q;
  logic [WIDTH-1:0]      wb_data_q;
  logic [CNT_WIDTH-1:0]  stall0_q;
  logic [CNT_WIDTH-1:0]  stall1_q;

  // Arbitration: prio only matters when both sources request together.
  assign contend = s0_valid & s1_valid;
  assign grant0  = s0_valid & (~s1_valid | (prio == SRC_ALU));
  assign grant1  = s1_valid & (~s0_valid | (prio == SRC_LSU));

  // Nothing is accepted while clear is high, so a request is never half-taken.
  assign s0_ready  = grant0 & ~clear;
  assign s1_ready  = grant1 & ~clear;
  assign any_grant = s0_ready | s1_ready;

  always_comb begin
    win_addr = s0_addr;
    win_data = s0_data;
    if (s1_ready) begin
      win_addr = s1_addr;
      win_data = s1_data;
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prio       <= SRC_ALU;
      wb_valid_q <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
    end else begin
      wb_valid_q <= any_grant;
      if (any_grant) begin
        wb_addr_q <= win_addr;
        wb_data_q <= win_data;
      end
      if (contend) begin
        prio <= s0_ready ? other_src(SRC_ALU) : other_src(SRC_LSU);
      end
    end
  end

  // Stall counters saturate rather than wrap so long stalls stay visible.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      stall0_q <= '0;
      stall1_q <= '0;
    end else begin
      if (s0_valid & ~s0_ready & ~&stall0_q) begin
        stall0_q <= stall0_q + 1'b1;
      end
      if (s1_valid & ~s1_ready & ~&stall1_q) begin
        stall1_q <= stall1_q + 1'b1;
      end
    end
  end

  assign stall0_cnt = stall0_q;
  assign stall1_cnt = stall1_q;

  // x0 writes complete the handshake but never reach the regfile.
  assign rf_we   = wb_valid_q & (wb_addr_q != ADDR_WIDTH'(REG_X0));
  assign rf_addr = wb_addr_q;
  assign rf_data = wb_data_q;

`ifdef RF_BYPASS_EN
  rf_bypass_mux #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass_a (
    .wb_valid (wb_valid_q),
    .wb_addr  (wb_addr_q),
    .wb_data  (wb_data_q),
    .rd_addr  (rd_addr_a),
    .rf_rdata (rf_rdata_a),
    .rdata    (rdata_a)
  );

  rf_bypass_mux #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_bypass_b (
    .wb_valid (wb_valid_q),
    .wb_addr  (wb_addr_q),
    .wb_data  (wb_data_q),
    .rd_addr  (rd_addr_b),
    .rf_rdata (rf_rdata_b),
    .rdata    (rdata_b)
  );
`else
  logic unused_rd_addr;

  assign unused_rd_addr = ^{rd_addr_a, rd_addr_b};
  assign rdata_a        = rf_rdata_a;
  assign rdata_b        = rf_rdata_b;
`endif

  // A stalled requester must hold its request stable until accepted.
  a_s0_hold: assert property (@(posedge clock) disable iff (clear)
    (s0_valid & ~s0_ready) |=> (s0_valid & $stable(s0_addr) & $stable(s0_data)));
  a_s1_hold: assert property (@(posedge clock) disable iff (clear)
    (s1_valid & ~s1_ready) |=> (s1_valid & $stable(s1_addr) & $stable(s1_data)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: randomized and directed writeback traffic
// against a reference model; a negedge monitor pops expectations and compares.
module tb_regfile_wb_arbiter;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock;
  logic          clear;
  logic          s0_valid, s1_valid;
  logic [AW-1:0] s0_addr, s1_addr;
  logic [W-1:0]  s0_data, s1_data;
  logic          s0_ready, s1_ready;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [W-1:0]  rf_data;
  logic [AW-1:0] rd_addr_a, rd_addr_b;
  logic [W-1:0]  rf_rdata_a, rf_rdata_b;
  logic [W-1:0]  rdata_a, rdata_b;
  logic [CW-1:0] stall0_cnt, stall1_cnt;

  regfile_wb_arbiter #(.WIDTH(W), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clock      (clock),
    .clear      (clear),
    .s0_valid   (s0_valid),
    .s0_addr    (s0_addr),
    .s0_data    (s0_data),
    .s0_ready   (s0_ready),
    .s1_valid   (s1_valid),
    .s1_addr    (s1_addr),
    .s1_data    (s1_data),
    .s1_ready   (s1_ready),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .rd_addr_a  (rd_addr_a),
    .rd_addr_b  (rd_addr_b),
    .rf_rdata_a (rf_rdata_a),
    .rf_rdata_b (rf_rdata_b),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .stall0_cnt (stall0_cnt),
    .stall1_cnt (stall1_cnt)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  typedef struct {
    logic        rdy0, rdy1, we;
    logic [31:0] c0, c1, ra, rb;
  } cyc_t;

  typedef struct {
    logic [AW-1:0] a;
    logic [W-1:0]  d;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model state: contended cycles alternate winners starting at src0.
  int            n_cont;
  bit            inf_v;
  logic [AW-1:0] inf_a;
  logic [W-1:0]  inf_d;
  int            cnt0, cnt1;

  bit            p0, p1;
  logic [AW-1:0] pa0, pa1;
  logic [W-1:0]  pd0, pd1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_rd(input logic [AW-1:0] ra, input logic [W-1:0] rf);
    if (BYP && inf_v && (inf_a == ra) && (ra != 0)) return inf_d;
    return rf;
  endfunction

  task automatic model_reset();
    n_cont = 0;
    inf_v  = 1'b0;
    inf_a  = '0;
    inf_d  = '0;
    cnt0   = 0;
    cnt1   = 0;
    p0     = 1'b0;
    p1     = 1'b0;
    wr_q.delete();
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input bit v0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                      input bit v1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [W-1:0] fa, input logic [W-1:0] fb,
                      output bit g0, output bit g1);
    cyc_t rec;
    s0_valid = v0; s0_addr = a0; s0_data = d0;
    s1_valid = v1; s1_addr = a1; s1_data = d1;
    rd_addr_a = ra; rd_addr_b = rb; rf_rdata_a = fa; rf_rdata_b = fb;
    if (v0 && v1) begin
      g0 = (n_cont % 2) == 0;
      g1 = !g0;
      n_cont++;
    end else begin
      g0 = v0;
      g1 = v1;
    end
    rec.rdy0 = g0;
    rec.rdy1 = g1;
    rec.we   = inf_v && (inf_a != 0);
    rec.c0   = cnt0;
    rec.c1   = cnt1;
    rec.ra   = exp_rd(ra, fa);
    rec.rb   = exp_rd(rb, fb);
    cyc_q.push_back(rec);
    inf_v = g0 || g1;
    if (inf_v) begin
      inf_a = g0 ? a0 : a1;
      inf_d = g0 ? d0 : d1;
      if (inf_a != 0) wr_q.push_back('{a: inf_a, d: inf_d});
    end
    if (v0 && !g0 && cnt0 < CNT_MAX) cnt0++;
    if (v1 && !g1 && cnt1 < CNT_MAX) cnt1++;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                      input logic [W-1:0] fa, input logic [W-1:0] fb);
    bit g0, g1;
    step(0, '0, '0, 0, '0, '0, ra, rb, fa, fb, g0, g1);
  endtask

  task automatic traffic(input int n, input int pc0, input int pc1,
                         input int a0lo, input int a0hi, input int a1lo, input int a1hi);
    bit g0, g1;
    logic [AW-1:0] ra, rb;
    for (int k = 0; k < n; k++) begin
      if (!p0 && $urandom_range(0, 99) < pc0) begin
        p0 = 1'b1; pa0 = AW'($urandom_range(a0lo, a0hi)); pd0 = $urandom;
      end
      if (!p1 && $urandom_range(0, 99) < pc1) begin
        p1 = 1'b1; pa1 = AW'($urandom_range(a1lo, a1hi)); pd1 = $urandom;
      end
      ra = ($urandom_range(0, 1) == 1) ? inf_a : AW'($urandom_range(0, 7));
      rb = ($urandom_range(0, 1) == 1) ? inf_a : AW'($urandom_range(0, 7));
      step(p0, pa0, pd0, p1, pa1, pd1, ra, rb, $urandom, $urandom, g0, g1);
      if (g0) p0 = 1'b0;
      if (g1) p1 = 1'b0;
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 4 && (p0 || p1); k++) traffic(1, 0, 0, 0, 0, 0, 0);
  endtask

  // Reset asserted mid-cycle with a requester present; entered and left at posedge+1.
  task automatic rst_mid();
    check("pre_reset_rf_we", rf_we, inf_v && (inf_a != 0));
    s0_valid = 1'b1; s0_addr = 5'd3; s0_data = 32'h0BAD_F00D;
    s1_valid = 1'b0;
    #1 clear = 1'b1;
    #1;
    check("rst_rf_we", rf_we, 0);
    check("rst_s0_ready", s0_ready, 0);
    check("rst_s1_ready", s1_ready, 0);
    check("rst_stall0", stall0_cnt, 0);
    check("rst_stall1", stall1_cnt, 0);
    model_reset();
    @(posedge clock);
    #1;
    clear = 1'b0;
    s0_valid = 1'b0;
  endtask

  // Monitor: per-cycle expectations plus a write scoreboard popped on every rf_we.
  always @(negedge clock) begin
    cyc_t rec;
    wr_t  w;
    if (cyc_q.size() > 0) begin
      rec = cyc_q.pop_front();
      check("s0_ready", s0_ready, rec.rdy0);
      check("s1_ready", s1_ready, rec.rdy1);
      check("rf_we", rf_we, rec.we);
      check("stall0_cnt", stall0_cnt, rec.c0);
      check("stall1_cnt", stall1_cnt, rec.c1);
      check("rdata_a", rdata_a, rec.ra);
      check("rdata_b", rdata_b, rec.rb);
    end
    if (rf_we === 1'b1) begin
      if (wr_q.size() == 0) begin
        n_chk++;
        $display("FAIL rf_write_extra: got write to %0h, want none (t=%0t)", rf_addr, $time);
      end else begin
        w = wr_q.pop_front();
        check("rf_addr", rf_addr, w.a);
        check("rf_data", rf_data, w.d);
      end
    end
  end

  initial begin
    bit g0, g1;
    clear = 1'b0;
    s0_valid = 1'b0; s0_addr = '0; s0_data = '0;
    s1_valid = 1'b0; s1_addr = '0; s1_data = '0;
    rd_addr_a = '0; rd_addr_b = '0; rf_rdata_a = '0; rf_rdata_b = '0;
    model_reset();
    #1 clear = 1'b1;
    s0_valid = 1'b1; s0_addr = 5'd5; s0_data = 32'h1;
    #1;
    check("init_rf_we", rf_we, 0);
    check("init_rf_addr", rf_addr, 0);
    check("init_rf_data", rf_data, 0);
    check("init_s0_ready", s0_ready, 0);
    check("init_stall0", stall0_cnt, 0);
    check("init_stall1", stall1_cnt, 0);
    @(posedge clock);
    #1;
    clear = 1'b0;
    s0_valid = 1'b0;

    // Lone ALU write, then a write in flight when clear hits.
    step(1, 5'd5, 32'hDEAD_BEEF, 0, '0, '0, 5'd0, 5'd0, 32'h0, 32'h0, g0, g1);
    idle(5'd5, 5'd1, 32'h1111, 32'h2222);
    step(1, 5'd9, 32'h0000_0011, 0, '0, '0, 5'd0, 5'd0, 32'h0, 32'h0, g0, g1);
    rst_mid();

    // Contention held four cycles from reset priority, then drain.
    traffic(4, 100, 100, 1, 1, 2, 2);
    drain();
    idle(5'd1, 5'd2, 32'h0, 32'h0);

    // x0 write from LSU, then bypass of an in-flight write to x7.
    step(0, '0, '0, 1, 5'd0, 32'h1234, 5'd0, 5'd0, 32'h0, 32'h0, g0, g1);
    idle(5'd0, 5'd0, 32'h5555_5555, 32'h6666_6666);
    step(1, 5'd7, 32'hA5A5_A5A5, 0, '0, '0, 5'd0, 5'd0, 32'h0, 32'h0, g0, g1);
    idle(5'd3, 5'd7, 32'h7777_7777, 32'h0);

    // Long contention drives both counters into saturation.
    rst_mid();
    traffic(40, 100, 100, 0, 7, 0, 7);
    drain();
    idle(5'd0, 5'd0, 32'h0, 32'h0);

    // Random traffic with periodic resets.
    for (int r = 0; r < 5; r++) begin
      traffic(300, 30 + 15 * r, 70 - 10 * r, 0, 7, 0, 7);
      drain();
      traffic(1, 0, 0, 0, 0, 0, 0);
      rst_mid();
    end
    idle(5'd0, 5'd0, 32'h0, 32'h0);
    idle(5'd0, 5'd0, 32'h0, 32'h0);
    check("writes_drained", wr_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
